// File: rtl/step_pacer_pkg.sv
// step_pacer shared types.
// State encoding and datapath width for the step pacer.
package step_pacer_pkg;

  localparam int PACER_PERIOD_W = 32;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    DRAIN   = 2'd2
  } pacer_state_t;

endpackage

// File: rtl/step_pacer_if.sv
// Step token handshake between pacer and step engine.
// The pacer is master; the step engine is slave.
interface step_pacer_if;
  import step_pacer_pkg::*;

  logic                      step_valid_out;
  logic                      step_ready_in;
  logic [PACER_PERIOD_W-1:0] step_index_out;

  modport master (
    output step_valid_out,
    output step_index_out,
    input  step_ready_in
  );

  modport slave (
    input  step_valid_out,
    input  step_index_out,
    output step_ready_in
  );

endinterface

// File: rtl/step_pacer_counter.sv
// Saturating up/down counter with full flag and drop pulse.
// Holds the pending-token count for the pacer.
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc_in,
  input  logic         dec_in,
  output logic [W-1:0] count_out,
  output logic [W-1:0] count_nxt_out,
  output logic         full_out,
  output logic         drop_out
);

  logic [W-1:0] count_q;

  always_comb begin
    full_out      = &count_q;
    drop_out      = 1'b0;
    count_nxt_out = count_q;
    if (inc_in && !dec_in) begin
      if (full_out)
        drop_out = 1'b1;
      else
        count_nxt_out = count_q + 1'b1;
    end else if (dec_in && !inc_in && count_q != '0) begin
      count_nxt_out = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      count_q <= '0;
    else
      count_q <= count_nxt_out;
  end

  assign count_out = count_q;

endmodule

// File: rtl/step_pacer.sv
// Step pacer: period ticks -> buffered step tokens.
// Run/stop/drain FSM gates token generation.
module step_pacer
  import step_pacer_pkg::*;
#(
  parameter int PENDING_W = 4,
  parameter int OVF_W     = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [PACER_PERIOD_W-1:0] count_in,
  input  logic [PACER_PERIOD_W-1:0] period_in,
  input  logic                      run_in,
  input  logic                      stop_in,
  input  logic                      step_in,
  step_pacer_if.master              step_if,
  output logic [PENDING_W-1:0]      pending_out,
  output logic [OVF_W-1:0]          overrun_count_out,
  output logic [1:0]                state_out
);

  pacer_state_t state_q, state_d;

  logic                      tick_q;
  logic                      add;
  logic                      accept;
  logic                      drop;
  logic                      full;
  logic [PENDING_W-1:0]      pending;
  logic [PENDING_W-1:0]      pending_nxt;
  logic [PACER_PERIOD_W-1:0] index_q;
  logic [OVF_W-1:0]          ovf_q;

  // period 0 wraps to a match at all-ones
  always_ff @(posedge clk_in) begin
    if (rst_in)
      tick_q <= 1'b0;
    else
      tick_q <= (count_in == period_in - 32'd1);
  end

  assign add = (state_q == RUNNING && tick_q) ||
               (state_q == STOPPED && step_in &&
                pending == '0);

  assign accept = step_if.step_valid_out &&
                  step_if.step_ready_in;

  sat_updown_counter #(
    .W (PENDING_W)
  ) u_pending (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .inc_in        (add),
    .dec_in        (accept),
    .count_out     (pending),
    .count_nxt_out (pending_nxt),
    .full_out      (full),
    .drop_out      (drop)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      index_q <= '0;
      ovf_q   <= '0;
    end else begin
      if (accept)
        index_q <= index_q + 32'd1;
      if (drop && !(&ovf_q))
        ovf_q <= ovf_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (run_in && !stop_in) state_d = RUNNING;
      RUNNING: if (stop_in)
                 state_d = (pending_nxt != '0) ? DRAIN : STOPPED;
      DRAIN: begin
        if (run_in && !stop_in)
          state_d = RUNNING;
        else if (pending_nxt == '0)
          state_d = STOPPED;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_q <= STOPPED;
    else
      state_q <= state_d;
  end

  assign step_if.step_valid_out = (pending != '0);
  assign step_if.step_index_out = index_q;
  assign pending_out            = pending;
  assign overrun_count_out      = ovf_q;
  assign state_out              = state_q;

endmodule
